// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver (and transmitter).
// Holds the receiver state encoding, frame geometry and a small vote helper
// used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Line levels of the framing bits.
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } uart_rx_state_e;

  // Two-out-of-three vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for asynchronous inputs, reset to 1
// so an idle-high serial line does not look like a start edge out of reset.
// q is the fully synchronized value; q_early is the first stage, which is
// one cycle ahead of q and only meant to be used as one vote among several.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_early
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Two-stage resynchronization of each bit into the clk domain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage1_reg[gi] <= 1'b1;
          stage2_reg[gi] <= 1'b1;
        end else begin
          stage1_reg[gi] <= d[gi];
          stage2_reg[gi] <= stage1_reg[gi];
        end
      end
    end
  endgenerate

  assign q       = stage2_reg;
  assign q_early = stage1_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a one-entry
// valid/ack output register.
// Optional macro UART_RX_MAJORITY_EN: each start/data/stop sample becomes a
// 2-of-3 vote of rx_s at timer values mid-1, mid, mid+1 with unchanged
// latency (the mid+1 value is taken from the synchronizer's first stage).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic sample;

  uart_rx_state_e       state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                 load_byte;
  logic                 stop_err;

`ifdef UART_RX_MAJORITY_EN
  logic rx_early;
  logic rx_prev_reg;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d       (rx),
    .q       (rx_s),
    .q_early (rx_early)
  );

  // One-cycle history of rx_s provides the mid-1 vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev_reg <= 1'b1;
    else     rx_prev_reg <= rx_s;
  end

  assign sample = maj3(rx_prev_reg, rx_s, rx_early);
`else
  logic rx_early_unused;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d       (rx),
    .q       (rx_s),
    .q_early (rx_early_unused)
  );

  assign sample = rx_s;
`endif

  // Frame state, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
    end
  end

  // Next-state logic: frame tracking and per-bit sampling decisions.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
    load_byte  = 1'b0;
    stop_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_s == UART_START_BIT) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          idx_next = '0;
          // A start bit that is already gone by mid-bit was a glitch.
          if (sample != UART_START_BIT) state_next = IDLE;
          else                          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          shreg_next = {sample, shreg_reg[DATA_BITS-1:1]};
          cnt_next   = '0;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == IDX_LAST) state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch the next start.
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (sample == UART_STOP_BIT) begin
            load_byte  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_err   = 1'b1;
            state_next = RECOVER;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RECOVER: begin
        // A held-low (break) line must return high before a new frame.
        if (rx_s == UART_STOP_BIT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register with valid/ack handshake, overrun and frame error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_err;
      if (load_byte) begin
        data_out   <= shreg_reg;
        data_valid <= 1'b1;
        if (data_valid && !data_ack) overrun <= 1'b1;
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors;
  int miscompares;
  int fe_cycles;

  logic dv_trace   [0:FRAME-1];
  logic busy_trace [0:FRAME-1];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle frame_err is high, so a stretched pulse is visible.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line level during cycle c of a frame: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return stop;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int ack_cycle, input int glitch_cycle);
    for (int c = 0; c < FRAME; c++) begin
      rx = frame_bit(b, stop, c);
      if (c == glitch_cycle) rx = ~rx;
      data_ack = (c == ack_cycle);
      tick(1);
      dv_trace[c]   = data_valid;
      busy_trace[c] = busy;
    end
    data_ack = 1'b0;
    rx       = 1'b1;
    $display("frame %02h stop=%0b: data_out=%02h data_valid=%0b overrun=%0b",
             b, stop, data_out, data_valid, overrun);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; data_ack = 1'b0;
    tick(3);
    vectors++;
    if ({data_out, data_valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_in: outputs %h required 000", {data_out, data_valid, frame_err, overrun, busy});
    end
    rst = 1'b0;
    tick(4);
    vectors++;
    if ({data_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_out: dv/busy %b required 00", {data_valid, busy});
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1, -1);
    vectors++;
    if (dv_trace[153] !== 1'b0 || dv_trace[154] !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: dv@E153=%b dv@E154=%b required 0 1", dv_trace[153], dv_trace[154]);
    end
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_data: got %02h required a5", data_out);
    end
    vectors++;
    if (busy_trace[80] !== 1'b1 || busy !== 1'b0 || fe_cycles != 0) begin
      miscompares++;
      $display("FAIL basic_busy: mid=%b end=%b fe=%0d required 1 0 0", busy_trace[80], busy, fe_cycles);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, 5, -1);
    vectors++;
    if (data_out !== 8'h3C || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got %02h/%b required 3c/1", data_out, data_valid);
    end
    send_frame(8'hC3, 1'b1, 5, -1);
    vectors++;
    if (dv_trace[10] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ack: dv after ack %b required 0", dv_trace[10]);
    end
    vectors++;
    if (data_out !== 8'hC3 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got %02h/%b/%b required c3/1/0", data_out, data_valid, overrun);
    end
  endtask

  task automatic test_overrun();
    ack_pulse();
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_ack: dv %b required 0", data_valid);
    end
    send_frame(8'h11, 1'b1, -1, -1);
    vectors++;
    if (data_out !== 8'h11 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_first: got %02h/%b required 11/0", data_out, overrun);
    end
    send_frame(8'h22, 1'b1, -1, -1);
    vectors++;
    if (data_out !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set: got %02h/%b/%b required 22/1/1", data_out, data_valid, overrun);
    end
    ack_pulse();
    vectors++;
    if (data_valid !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear: dv/ovr %b%b required 00", data_valid, overrun);
    end
  endtask

  task automatic test_same_edge_ack();
    send_frame(8'h5A, 1'b1, -1, -1);
    send_frame(8'h6B, 1'b1, 154, -1);
    vectors++;
    if (data_out !== 8'h6B || data_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL same_edge: got %02h/%b/%b required 6b/1/0", data_out, data_valid, overrun);
    end
  endtask

  task automatic test_frame_error();
    int fe_base;
    fe_base = fe_cycles;
    send_frame(8'h55, 1'b0, -1, -1);
    rx = 1'b0;
    tick(40 * CPB);
    vectors++;
    if (fe_cycles - fe_base != 1) begin
      miscompares++;
      $display("FAIL ferr_pulse: %0d cycles high required 1", fe_cycles - fe_base);
    end
    vectors++;
    if (data_out !== 8'h6B || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_keep: got %02h/%b required 6b/1", data_out, data_valid);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_recover: busy %b required 1", busy);
    end
    rx = 1'b1;
    tick(4);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_idle: busy %b required 0", busy);
    end
    ack_pulse();
    send_frame(8'h0F, 1'b1, -1, -1);
    vectors++;
    if (data_out !== 8'h0F || data_valid !== 1'b1 || overrun !== 1'b0 || fe_cycles - fe_base != 1) begin
      miscompares++;
      $display("FAIL ferr_next: got %02h/%b/%b fe=%0d required 0f/1/0 fe=1",
               data_out, data_valid, overrun, fe_cycles - fe_base);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_ff;
    rx = 1'b0;
    tick(3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_start: busy %b required 1", busy);
    end
    rx = 1'b1;
    tick(7);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_hold: busy at E9 %b required 1", busy);
    end
    tick(1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_drop: busy at E10 %b required 0", busy);
    end
    tick(20);
    vectors++;
    if (data_out !== 8'h0F || data_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_nobyte: got %02h/%b/%b required 0f/1/0", data_out, data_valid, overrun);
    end
    // One-cycle low at the nominal sample of data bit 3.
`ifdef UART_RX_MAJORITY_EN
    exp_ff = 8'hFF;
`else
    exp_ff = 8'hF7;
`endif
    ack_pulse();
    send_frame(8'hFF, 1'b1, -1, 72);
    vectors++;
    if (data_out !== exp_ff) begin
      miscompares++;
      $display("FAIL glitch_bit3: got %02h required %02h", data_out, exp_ff);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h33, 1'b1, -1, -1);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: overrun %b required 1", overrun);
    end
    for (int c = 0; c < 85; c++) begin
      rx = frame_bit(8'h99, 1'b1, c);
      tick(1);
    end
    rst = 1'b1;
    #2;
    vectors++;
    if ({data_out, data_valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL rstmid_async: outputs %h required 000", {data_out, data_valid, frame_err, overrun, busy});
    end
    tick(1);
    rx  = 1'b1;
    rst = 1'b0;
    tick(3);
    send_frame(8'h42, 1'b1, -1, -1);
    vectors++;
    if (data_out !== 8'h42 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_next: got %02h/%b/%b required 42/1/0", data_out, data_valid, overrun);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fe_cycles   = 0;
    rst         = 1'b1;
    rx          = 1'b1;
    data_ack    = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_same_edge_ack();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
